pc_fetch_sequencer: RTL and testbench

//  Program-counter and instruction-fetch sequencer directly upstream of Controller.

---
 rtl/pc_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter / instruction-fetch sequencer feeding Controller; one fetch in flight.
// Optional MISALIGN_TRAP_EN: a misaligned Jr target halts the sequencer instead of being word-aligned.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        br_cond,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        fetch_err,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(IM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic        is_br;
    logic [31:0] next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Branch alone is not enough: Controller also raises it for slt/slti.
    assign seq_pc = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign is_br  = (instr_q[31:26] == 6'b000100) || (instr_q[31:26] == 6'b000101);

    always_comb begin
        next_pc = seq_pc;
        if (Jr) begin
            next_pc = rs_data & 32'hFFFF_FFFC;
        end else if (Jump) begin
            next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && is_br && br_cond) begin
            next_pc = seq_pc + br_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                cnt_d = '0;
                if (im_ready) begin
                    instr_d = im_rdata;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (im_ready) begin
                    instr_d = im_rdata;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = cnt_q + 8'd1;
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (!stall) begin
`ifdef MISALIGN_TRAP_EN
                    if (Jr && (rs_data[1:0] != 2'b00)) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
`else
                    pc_d    = next_pc;
                    state_d = S_REQ;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign im_req      = (state_q == S_REQ) || (state_q == S_WAIT);
    assign im_addr     = pc_q;
    assign pc          = pc_q;
    assign link_addr   = seq_pc;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_EXEC);
    assign fetch_err   = err_q;
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed vector table, corner sequences,
// and random instruction streams checked against a transaction-level next-PC model.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned IM_TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        Branch, Jump, Jr, br_cond;
    logic [31:0] rs_data;
    logic        stall;
    logic        fetch_err;
    logic        halted;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] mpc;

    typedef struct {
        logic [31:0] word;
        int unsigned delay;
        bit          br;
        bit          jmp;
        bit          jr;
        bit          brc;
        logic [31:0] rs;
        int unsigned stl;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[17];

    pc_fetch_sequencer #(
        .RESET_PC  (RST_PC),
        .IM_TIMEOUT(IM_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ready   (im_ready),
        .im_rdata   (im_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .link_addr  (link_addr),
        .Branch     (Branch),
        .Jump       (Jump),
        .Jr         (Jr),
        .br_cond    (br_cond),
        .rs_data    (rs_data),
        .stall      (stall),
        .fetch_err  (fetch_err),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (mpc=%h)", name, act, exp, mpc);
        end
    endtask

    // Reference next-PC rule, straight from the instruction semantics.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input bit br, input bit jmp, input bit jr,
                                               input bit brc, input logic [31:0] rs);
        logic [31:0] seq;
        int unsigned op;
        int          off;
        seq = cur + 32'd4;
        op  = word >> 26;
        if (jr) return rs - (rs % 4);
        if (jmp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (br && (op == 4 || op == 5) && brc) begin
            off = int'($signed(word[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    task automatic clear_ctrl();
        Branch  = 1'b0;
        Jump    = 1'b0;
        Jr      = 1'b0;
        br_cond = 1'b0;
        rs_data = '0;
        stall   = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        im_ready = 1'b0;
        im_rdata = '0;
        clear_ctrl();
        tick();
        tick();
        chk("rst_im_req", {31'b0, im_req}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_im_addr", im_addr, RST_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        // a ready pulse while still idle must not load an instruction
        rst      = 1'b0;
        im_ready = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ready = 1'b0;
        chk("idle_to_req", {31'b0, im_req}, 32'd1);
        chk("idle_ready_ignored", instr, 32'd0);
        mpc = RST_PC;
    endtask

    task automatic fetch_to_exec(input logic [31:0] word, input int unsigned delay);
        chk("req", {31'b0, im_req}, 32'd1);
        chk("req_addr", im_addr, mpc);
        for (int unsigned d = 0; d < delay; d++) begin
            im_ready = 1'b0;
            tick();
            chk("wait_req", {31'b0, im_req}, 32'd1);
            chk("wait_addr", im_addr, mpc);
        end
        im_ready = 1'b1;
        im_rdata = word;
        tick();
        im_ready = 1'b0;
        im_rdata = $urandom;
        chk("exec_valid", {31'b0, instr_valid}, 32'd1);
        chk("exec_instr", instr, word);
        chk("exec_pc", pc, mpc);
        chk("exec_link", link_addr, mpc + 32'd4);
        chk("exec_no_req", {31'b0, im_req}, 32'd0);
        chk("exec_halted", {31'b0, halted}, 32'd0);
    endtask

    task automatic do_instr(input vec_t v);
        fetch_to_exec(v.word, v.delay);
        Branch  = v.br;
        Jump    = v.jmp;
        Jr      = v.jr;
        br_cond = v.brc;
        rs_data = v.rs;
        for (int unsigned s = 0; s < v.stl; s++) begin
            stall = 1'b1;
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", pc, mpc);
            chk("stall_instr", instr, v.word);
        end
        stall    = 1'b0;
        im_ready = 1'b1;
        im_rdata = ~v.word;
        tick();
        im_ready = 1'b0;
        clear_ctrl();
        chk("exec_ready_ignored", instr, v.word);
        mpc = v.nxt;
        chk("next_req", {31'b0, im_req}, 32'd1);
        chk("next_addr", im_addr, mpc);
    endtask

    initial begin
        vec_t        rv;
        int unsigned kind;

        tbl[0]  = '{32'h0000_0000,  0, 0, 0, 0, 0, 32'h0,          0, 32'h0000_0004};
        tbl[1]  = '{32'h0000_0000,  0, 0, 0, 0, 0, 32'h0,          0, 32'h0000_0008};
        tbl[2]  = '{32'h0800_0004,  0, 0, 1, 0, 0, 32'h0,          0, 32'h0000_0010};
        tbl[3]  = '{32'h1000_0003,  0, 1, 0, 0, 1, 32'h0,          0, 32'h0000_0020};
        tbl[4]  = '{32'h0800_0004,  0, 0, 1, 0, 0, 32'h0,          0, 32'h0000_0010};
        tbl[5]  = '{32'h1000_0003,  0, 1, 0, 0, 0, 32'h0,          0, 32'h0000_0014};
        tbl[6]  = '{32'h0000_002A,  0, 1, 0, 0, 1, 32'h0,          0, 32'h0000_0018};
        tbl[7]  = '{32'h0000_0000,  0, 0, 0, 1, 0, 32'h0000_0100,  0, 32'h0000_0100};
        tbl[8]  = '{32'h0800_0040,  0, 0, 1, 0, 0, 32'h0,          0, 32'h0000_0100};
        tbl[9]  = '{32'h0000_0000,  0, 0, 0, 1, 0, 32'h0000_0200,  0, 32'h0000_0200};
        tbl[10] = '{32'h0000_0000,  3, 0, 0, 0, 0, 32'h0,          4, 32'h0000_0204};
        tbl[11] = '{32'h1400_FFFE,  0, 1, 0, 0, 1, 32'h0,          0, 32'h0000_0200};
        tbl[12] = '{32'h0000_0000, 16, 0, 0, 1, 0, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC};
        tbl[13] = '{32'h0000_0000,  0, 0, 0, 0, 0, 32'h0,          0, 32'h0000_0000};
        tbl[14] = '{32'h1000_0003,  0, 1, 1, 1, 1, 32'h0000_0040,  0, 32'h0000_0040};
        tbl[15] = '{32'h1000_0003,  0, 1, 1, 0, 1, 32'h0,          0, 32'h0000_000C};
        tbl[16] = '{32'h0000_0000,  0, 0, 0, 0, 0, 32'h0,          1, 32'h0000_0010};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            do_instr(tbl[i]);
        end

        // misaligned Jr target at pc=0x10
        fetch_to_exec(32'h0000_0000, 0);
        Jr      = 1'b1;
        rs_data = 32'h0000_0203;
        tick();
        clear_ctrl();
`ifdef MISALIGN_TRAP_EN
        chk("mis_halted", {31'b0, halted}, 32'd1);
        chk("mis_pc", pc, mpc);
        chk("mis_no_req", {31'b0, im_req}, 32'd0);
        chk("mis_no_valid", {31'b0, instr_valid}, 32'd0);
`else
        chk("mis_halted", {31'b0, halted}, 32'd0);
        chk("mis_addr", im_addr, 32'h0000_0200);
        chk("mis_req", {31'b0, im_req}, 32'd1);
`endif
        chk("mis_err", {31'b0, fetch_err}, 32'd0);

        // random instruction stream
        do_reset();
        for (int i = 0; i < 60; i++) begin
            rv.word = $urandom;
            kind    = $urandom_range(0, 4);
            case (kind)
                0: rv.word[31:26] = 6'd4;
                1: rv.word[31:26] = 6'd5;
                2: rv.word[31:26] = 6'd2;
                3: rv.word[31:26] = 6'd0;
                default: ;
            endcase
            rv.br    = 1'($urandom_range(0, 1));
            rv.brc   = 1'($urandom_range(0, 1));
            rv.jmp   = ($urandom_range(0, 5) == 0);
            rv.jr    = ($urandom_range(0, 5) == 0);
            rv.rs    = $urandom;
`ifdef MISALIGN_TRAP_EN
            rv.rs[1:0] = 2'b00;
`endif
            rv.delay = $urandom_range(0, 5);
            rv.stl   = $urandom_range(0, 2);
            rv.nxt   = model_next(mpc, rv.word, rv.br, rv.jmp, rv.jr, rv.brc, rv.rs);
            do_instr(rv);
        end

        // reset while a fetch is outstanding
        do_reset();
        rv = '{32'h0000_0000, 0, 0, 0, 1, 0, 32'h0000_0300, 0, 32'h0000_0300};
        do_instr(rv);
        im_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("wait_before_rst", {31'b0, im_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_wait_req", {31'b0, im_req}, 32'd0);
        chk("rst_wait_pc", pc, RST_PC);
        chk("rst_wait_valid", {31'b0, instr_valid}, 32'd0);

        // fetch timeout
        do_reset();
        im_ready = 1'b0;
        for (int unsigned k = 0; k <= IM_TO; k++) begin
            chk("to_req", {31'b0, im_req}, 32'd1);
            chk("to_not_halted", {31'b0, halted}, 32'd0);
            tick();
        end
        chk("to_halted", {31'b0, halted}, 32'd1);
        chk("to_err", {31'b0, fetch_err}, 32'd1);
        chk("to_no_req", {31'b0, im_req}, 32'd0);
        chk("to_no_valid", {31'b0, instr_valid}, 32'd0);
        im_ready = 1'b1;
        im_rdata = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halt_sticky", {31'b0, halted}, 32'd1);
            chk("err_sticky", {31'b0, fetch_err}, 32'd1);
            chk("halt_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        im_ready = 1'b0;
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
